fetch_stage: RTL

- Instruction-fetch stage of the 5-stage RV32I pipeline.
- Owns the program counter and drives the combinational instruction memory address.
- Captures the returned word into the IF/ID pipeline register.
- Handles stall, branch/jump redirect (with squash), reset boot bubble and halt-on-EBREAK.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/ifid_reg.sv | 25 ++
 rtl/fetch_stage.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared RV32I pipeline types and default encodings used by the fetch stage and decode.
// Holds the fetch FSM state type and the IF/ID register layout.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT  = 32'h0000_0013;
    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0010_0073;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } ifid_t;

    // A bubble carries no PC information so decode never mistakes it for a real slot.
    function automatic ifid_t make_bubble(input logic [31:0] nop);
        ifid_t b;
        b.valid    = 1'b0;
        b.pc       = 32'h0;
        b.pc_plus4 = 32'h0;
        b.instr    = nop;
        return b;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: bubble overrides load, otherwise load or hold.
module ifid_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  bubble,
    input  ifid_t d,
    output ifid_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= make_bubble(NOP_INSTR);
        end else if (bubble) begin
            q <= make_bubble(NOP_INSTR);
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, BOOT/RUN/HALT control and IF/ID capture.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT,
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] ifid_instr,
    output logic        halted,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic         load, bubble;
    ifid_t        ifid_d, ifid_q;
    logic         unused_align_bits;

    // Redirect targets are forced word-aligned, so the low target bits are dropped.
    assign unused_align_bits = ^redirect_pc[1:0];

    assign imem_addr = pc;

    // Redirect beats stall, which beats the per-state action.
    always_comb begin
        pc_next    = pc;
        state_next = state;
        load       = 1'b0;
        bubble     = 1'b0;
        if (redirect_valid) begin
            pc_next    = {redirect_pc[31:2], 2'b00};
            state_next = RUN;
            bubble     = 1'b1;
        end else if (!stall) begin
            case (state)
                BOOT: begin
                    bubble     = 1'b1;
                    state_next = RUN;
                end
                RUN: begin
                    load = 1'b1;
                    if (imem_instr == HALT_INSTR) begin
                        state_next = HALT;
                    end else begin
                        pc_next = pc + 32'd4;
                    end
                end
                HALT: begin
                    bubble = 1'b1;
                end
                default: begin
                    bubble     = 1'b1;
                    state_next = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= BOOT;
            pc     <= {RESET_PC[31:2], 2'b00};
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            halted <= (state_next == HALT);
        end
    end

    always_comb begin
        ifid_d.valid    = 1'b1;
        ifid_d.pc       = pc;
        ifid_d.pc_plus4 = pc + 32'd4;
        ifid_d.instr    = imem_instr;
    end

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .bubble (bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign ifid_valid    = ifid_q.valid;
    assign ifid_pc       = ifid_q.pc;
    assign ifid_pc_plus4 = ifid_q.pc_plus4;
    assign ifid_instr    = ifid_q.instr;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, bubble_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt  <= 32'h0;
            bubble_cnt <= 32'h0;
        end else begin
            if (load) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (bubble) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end

    assign fetch_count  = fetch_cnt;
    assign bubble_count = bubble_cnt;
`else
    assign fetch_count  = 32'h0;
    assign bubble_count = 32'h0;
`endif

endmodule
